// File: rtl/oled_pkg.sv
// Shared constants, state encoding and small helpers for the OLED pixel streamer.
package oled_pkg;

  localparam int OLED_WIDTH  = 96;
  localparam int OLED_HEIGHT = 64;

  localparam logic [7:0] CMD_SET_COL = 8'h15;
  localparam logic [7:0] CMD_SET_ROW = 8'h75;

  localparam logic [15:0] RGB_RED    = 16'hF800;
  localparam logic [15:0] RGB_GREEN  = 16'h07E0;
  localparam logic [15:0] RGB_BLUE   = 16'h001F;
  localparam logic [15:0] RGB_WHITE  = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN   = 16'h07FF;
  localparam logic [15:0] RGB_BLACK  = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_PIXEL,
    ST_GAP
  } state_t;

  // Address-window preamble: column start/end, then row start/end.
  function automatic logic [7:0] cmd_byte(input logic [2:0] idx,
                                          input logic [7:0] last_col,
                                          input logic [7:0] last_row);
    case (idx)
      3'd0:    cmd_byte = CMD_SET_COL;
      3'd1:    cmd_byte = 8'h00;
      3'd2:    cmd_byte = last_col;
      3'd3:    cmd_byte = CMD_SET_ROW;
      3'd4:    cmd_byte = 8'h00;
      3'd5:    cmd_byte = last_row;
      default: cmd_byte = 8'h00;
    endcase
  endfunction

  function automatic logic [15:0] test_color(input logic [2:0] band);
    case (band)
      3'd0:    test_color = RGB_RED;
      3'd1:    test_color = RGB_GREEN;
      3'd2:    test_color = RGB_BLUE;
      3'd3:    test_color = RGB_WHITE;
      3'd4:    test_color = RGB_YELLOW;
      3'd5:    test_color = RGB_CYAN;
      default: test_color = RGB_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/oled_spi_shifter.sv
// Mode-3 SPI word shifter: loads 8 or 16 bits, MSB first, CLK_DIV clk per SCLK half-period.
module oled_spi_shifter #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_len16,
  input  logic [15:0] i_word,
  output logic        o_sclk,
  output logic        o_sdin,
  output logic        o_done
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic          r_active;
  logic          r_high;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bits;
  logic [15:0]   r_sh;
  logic          r_sclk;
  logic          r_sdin;
  logic          w_tick;

  assign w_tick = (r_cnt == CW'(CLK_DIV - 1));
  // done fires on the last cycle of the final high phase, so a load in that
  // same cycle starts the next word with no idle bit cell.
  assign o_done = r_active && r_high && w_tick && (r_bits == 4'd0);
  assign o_sclk = r_sclk;
  assign o_sdin = r_sdin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_high   <= 1'b1;
      r_cnt    <= '0;
      r_bits   <= '0;
      r_sh     <= '0;
      r_sclk   <= 1'b1;
      r_sdin   <= 1'b0;
    end else if (i_load) begin
      r_active <= 1'b1;
      r_high   <= 1'b0;
      r_cnt    <= '0;
      r_sclk   <= 1'b0;
      if (i_len16) begin
        r_sdin <= i_word[15];
        r_sh   <= {i_word[14:0], 1'b0};
        r_bits <= 4'd15;
      end else begin
        r_sdin <= i_word[7];
        r_sh   <= {i_word[6:0], 9'd0};
        r_bits <= 4'd7;
      end
    end else if (r_active) begin
      if (w_tick) begin
        r_cnt <= '0;
        if (!r_high) begin
          r_sclk <= 1'b1;
          r_high <= 1'b1;
        end else if (r_bits != 4'd0) begin
          r_sclk <= 1'b0;
          r_high <= 1'b0;
          r_sdin <= r_sh[15];
          r_sh   <= {r_sh[14:0], 1'b0};
          r_bits <= r_bits - 4'd1;
        end else begin
          r_active <= 1'b0;
        end
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/oled_pixel_streamer.sv
// Scans WIDTHxHEIGHT pixels and streams window commands plus RGB565 data over SPI.
// Define OLED_TEST_PATTERN_EN to replace oled_data with colour bars from x[6:4].
module oled_pixel_streamer
  import oled_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int WIDTH   = OLED_WIDTH,
  parameter int HEIGHT  = OLED_HEIGHT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [6:0]  x,
  output logic [5:0]  y,
  input  logic [15:0] oled_data,
  output logic        frame_start,
  output logic        busy,
  output logic        cs_n,
  output logic        sclk,
  output logic        sdin,
  output logic        d_cn
);

  localparam int CW   = $clog2(2 * CLK_DIV);
  localparam int NCMD = 6;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic          r_started;
  logic          r_last_pix;
  logic [6:0]    r_x;
  logic [5:0]    r_y;
  logic          r_fstart, r_busy, r_cs_n, r_d_cn;

  logic          w_load, w_len16, w_pix_load, w_done;
  logic [15:0]   w_word, w_pix;
  logic [7:0]    w_cmd;
  logic          w_setup_end, w_gap_end, w_frame_last;

`ifdef OLED_TEST_PATTERN_EN
  logic w_unused_data;
  assign w_unused_data = ^oled_data;
  assign w_pix = test_color(r_x[6:4]);
`else
  assign w_pix = oled_data;
`endif

  assign w_cmd        = cmd_byte(r_idx, 8'(WIDTH - 1), 8'(HEIGHT - 1));
  assign w_setup_end  = (r_cnt == CW'(CLK_DIV - 1));
  assign w_gap_end    = (r_cnt == CW'(2 * CLK_DIV - 1));
  assign w_frame_last = (r_x == 7'(WIDTH - 1)) && (r_y == 6'(HEIGHT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_len16     = 1'b0;
    w_word      = '0;
    w_pix_load  = 1'b0;
    case (r_state)
      ST_IDLE: if (en) w_state_nxt = ST_CMD;
      ST_CMD: begin
        if (!r_started) begin
          if (w_setup_end) begin
            w_load = 1'b1;
            w_word = {8'h00, w_cmd};
          end
        end else if (w_done) begin
          if (r_idx == 3'(NCMD)) begin
            w_pix_load  = 1'b1;
            w_state_nxt = ST_PIXEL;
          end else begin
            w_load = 1'b1;
            w_word = {8'h00, w_cmd};
          end
        end
      end
      ST_PIXEL: if (w_done) begin
        if (r_last_pix) w_state_nxt = ST_GAP;
        else            w_pix_load  = 1'b1;
      end
      ST_GAP: if (w_gap_end) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_pix_load) begin
      w_load  = 1'b1;
      w_len16 = 1'b1;
      w_word  = w_pix;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_started  <= 1'b0;
      r_last_pix <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
      r_fstart   <= 1'b0;
      r_busy     <= 1'b0;
      r_cs_n     <= 1'b1;
      r_d_cn     <= 1'b0;
    end else begin
      r_fstart <= 1'b0;
      case (r_state)
        ST_IDLE: if (en) begin
          r_fstart  <= 1'b1;
          r_busy    <= 1'b1;
          r_cs_n    <= 1'b0;
          r_d_cn    <= 1'b0;
          r_cnt     <= '0;
          r_idx     <= '0;
          r_started <= 1'b0;
        end
        ST_CMD: if (!r_started) begin
          r_cnt <= r_cnt + 1'b1;
          if (w_load) r_started <= 1'b1;
        end
        ST_PIXEL: if (w_state_nxt == ST_GAP) begin
          r_cs_n <= 1'b1;
          r_busy <= 1'b0;
          r_cnt  <= '0;
        end
        ST_GAP: r_cnt <= r_cnt + 1'b1;
        default: ;
      endcase
      if (w_load && !w_len16) r_idx <= r_idx + 1'b1;
      // x/y step on the load edge so the next lookup settles for a whole word.
      if (w_pix_load) begin
        r_d_cn     <= 1'b1;
        r_last_pix <= w_frame_last;
        if (r_x == 7'(WIDTH - 1)) begin
          r_x <= '0;
          r_y <= (r_y == 6'(HEIGHT - 1)) ? '0 : r_y + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
      end
    end
  end

  oled_spi_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_len16(w_len16),
    .i_word (w_word),
    .o_sclk (sclk),
    .o_sdin (sdin),
    .o_done (w_done)
  );

  assign x           = r_x;
  assign y           = r_y;
  assign frame_start = r_fstart;
  assign busy        = r_busy;
  assign cs_n        = r_cs_n;
  assign d_cn        = r_d_cn;

endmodule

// File: tb/tb_oled_pixel_streamer.sv
// Bench for oled_pixel_streamer: decodes the SPI stream and checks it against a frame model.
module tb_oled_pixel_streamer;

  localparam int CD     = 2;
  localparam int W      = 96;
  localparam int H      = 4;
  localparam int NPIX   = W * H;
  localparam int NWORDS = 6 + NPIX;
  localparam int PERIOD = (48 + NPIX * 16) * 2 * CD + CD + 2 * CD + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [6:0]  x;
  logic [5:0]  y;
  logic [15:0] oled_data;
  logic        frame_start, busy, cs_n, sclk, sdin, d_cn;

  always #5 clk = ~clk;

  // Screen content stand-in: colour encodes its own coordinates.
  assign oled_data = {3'b000, y, x};

  oled_pixel_streamer #(.CLK_DIV(CD), .WIDTH(W), .HEIGHT(H)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .x          (x),
    .y          (y),
    .oled_data  (oled_data),
    .frame_start(frame_start),
    .busy       (busy),
    .cs_n       (cs_n),
    .sclk       (sclk),
    .sdin       (sdin),
    .d_cn       (d_cn)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_cmd(input int i);
    case (i)
      0: exp_cmd = 8'h15;
      1: exp_cmd = 8'h00;
      2: exp_cmd = 8'(W - 1);
      3: exp_cmd = 8'h75;
      4: exp_cmd = 8'h00;
      default: exp_cmd = 8'(H - 1);
    endcase
  endfunction

  function automatic logic [15:0] exp_pix(input int k);
    int px, py;
    px = k % W;
    py = k / W;
`ifdef OLED_TEST_PATTERN_EN
    case (px / 16)
      0: exp_pix = 16'hF800;
      1: exp_pix = 16'h07E0;
      2: exp_pix = 16'h001F;
      3: exp_pix = 16'hFFFF;
      4: exp_pix = 16'hFFE0;
      5: exp_pix = 16'h07FF;
      default: exp_pix = 16'h0000;
    endcase
`else
    exp_pix = {3'b000, 6'(py), 7'(px)};
`endif
  endfunction

  // Monitor state
  int          cyc = 0;
  logic        p_sclk = 1'b1, p_cs = 1'b1, p_sdin = 1'b0, p_dcn = 1'b0;
  int          t_csfall = 0, t_fall = 0, t_rise = 0;
  bit          first_fall = 1'b0;
  int          nbits = 0, wi = 0, pix_seen = 0;
  logic [15:0] acc = '0;
  bit          dcn_ok = 1'b1;
  logic        exp_dcn;
  int          fs_count = 0, frames_done = 0, frame_words_last = 0;
  int          fs_time[8];
  logic [7:0]  cap_cmd[6];
  logic [15:0] cap_pix[NPIX];

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      nbits = 0;
      wi    = 0;
      acc   = '0;
    end else begin
      check("busy_vs_cs_n", {31'd0, busy}, {31'd0, !cs_n});
      if (cs_n) check("sclk_idle_high", {31'd0, sclk}, 32'd1);
      check("frame_start_pulse", {31'd0, frame_start}, {31'd0, (p_cs && !cs_n)});
      if (frame_start) begin
        if (fs_count < 8) fs_time[fs_count] = cyc;
        fs_count++;
        wi = 0; nbits = 0; pix_seen = 0;
        t_csfall = cyc;
        first_fall = 1'b1;
      end
      if (p_sclk && !sclk) begin
        if (first_fall) check("setup_cycles", cyc - t_csfall, CD);
        else            check("bit_cell", cyc - t_fall, 2 * CD);
        first_fall = 1'b0;
        t_fall = cyc;
      end
      if (!p_sclk && sclk) begin
        check("sclk_low_len", cyc - t_fall, CD);
        t_rise = cyc;
        if (nbits == 0) dcn_ok = 1'b1;
        exp_dcn = (wi >= 6);
        if (d_cn !== exp_dcn) dcn_ok = 1'b0;
        acc = {acc[14:0], sdin};
        nbits++;
        if (nbits == ((wi < 6) ? 8 : 16)) begin
          check("d_cn_word", {31'd0, dcn_ok}, 32'd1);
          if (wi < 6) begin
            check("cmd_byte", {24'd0, acc[7:0]}, {24'd0, exp_cmd(wi)});
            if (fs_count == 1) cap_cmd[wi] = acc[7:0];
          end else if (wi - 6 < NPIX) begin
            check("pixel_word", {16'd0, acc}, {16'd0, exp_pix(wi - 6)});
            if (fs_count == 1) cap_pix[wi - 6] = acc;
            pix_seen = wi - 5;
          end else begin
            check("words_in_frame_live", wi, NWORDS - 1);
          end
          wi++;
          nbits = 0;
        end
      end
      if (sdin !== p_sdin) check("sdin_moves_on_fall", {31'd0, (p_sclk && !sclk)}, 32'd1);
      if (d_cn !== p_dcn)  check("d_cn_moves_sclk_high", {31'd0, p_sclk}, 32'd1);
      if (!p_cs && cs_n) begin
        check("last_high_len", cyc - t_rise, CD);
        check("words_per_frame", wi, NWORDS);
        check("xy_zero_at_end", {19'd0, x, y}, 32'd0);
        frame_words_last = wi;
        frames_done++;
      end
    end
    p_sclk = sclk;
    p_cs   = cs_n;
    p_sdin = sdin;
    p_dcn  = d_cn;
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_cs_n"},        {31'd0, cs_n},        32'd1);
    check({tag, "_sclk"},        {31'd0, sclk},        32'd1);
    check({tag, "_sdin"},        {31'd0, sdin},        32'd0);
    check({tag, "_d_cn"},        {31'd0, d_cn},        32'd0);
    check({tag, "_x"},           {25'd0, x},           32'd0);
    check({tag, "_y"},           {26'd0, y},           32'd0);
    check({tag, "_frame_start"}, {31'd0, frame_start}, 32'd0);
    check({tag, "_busy"},        {31'd0, busy},        32'd0);
  endtask

  initial begin
    int n;
    int bad;

    repeat (3) @(negedge clk);
    check_reset_values("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("idle_cs_n", {31'd0, cs_n}, 32'd1);
    check("idle_no_frame", fs_count, 0);

    // Continuous streaming: two frame starts, period and decoded content.
    en = 1'b1;
    n = 0;
    while (fs_count < 2 && n < 2 * PERIOD + 100) begin @(negedge clk); n++; end
    check("two_frame_starts", fs_count, 2);
    check("frame_period", fs_time[1] - fs_time[0], PERIOD);
    check("frame1_words", frame_words_last, 390);
    check("cmd0", {24'd0, cap_cmd[0]}, 32'h15);
    check("cmd1", {24'd0, cap_cmd[1]}, 32'h00);
    check("cmd2", {24'd0, cap_cmd[2]}, 32'h5F);
    check("cmd3", {24'd0, cap_cmd[3]}, 32'h75);
    check("cmd4", {24'd0, cap_cmd[4]}, 32'h00);
    check("cmd5", {24'd0, cap_cmd[5]}, 32'h03);
`ifdef OLED_TEST_PATTERN_EN
    check("pix_x20", {16'd0, cap_pix[20]}, 32'h07E0);
    check("pix_x90", {16'd0, cap_pix[90]}, 32'h07FF);
`else
    check("pix0",   {16'd0, cap_pix[0]},   32'h0000);
    check("pix1",   {16'd0, cap_pix[1]},   32'h0001);
    check("pix96",  {16'd0, cap_pix[96]},  32'h0080);
    check("pix383", {16'd0, cap_pix[383]}, 32'h01DF);
`endif

    // Drop en mid-frame: the frame must complete and no new one may start.
    n = 0;
    while (pix_seen < 100 && n < PERIOD) begin @(negedge clk); n++; end
    check("reached_pixel_100", {31'd0, (pix_seen >= 100)}, 32'd1);
    en = 1'b0;
    n = 0;
    while (frames_done < 2 && n < PERIOD) begin @(negedge clk); n++; end
    check("frame2_done", frames_done, 2);
    check("frame2_words", frame_words_last, 390);
    repeat (200) @(negedge clk);
    check("no_restart", fs_count, 2);
    check("stop_cs_n", {31'd0, cs_n}, 32'd1);
    check("stop_busy", {31'd0, busy}, 32'd0);

    // Reset during PIXEL.
    en = 1'b1;
    n = 0;
    while (fs_count < 3 && n < 50) begin @(negedge clk); n++; end
    check("frame3_start", fs_count, 3);
    n = 0;
    while (pix_seen < 10 && n < PERIOD) begin @(negedge clk); n++; end
    check("frame3_in_pixel", {31'd0, d_cn}, 32'd1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1 check_reset_values("midrst");
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (sclk !== 1'b1) bad++;
    end
    check("sclk_still_in_reset", bad, 0);
    en = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("after_reset_cs_n", {31'd0, cs_n}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
